// File: rtl/ase_pkg.sv
// ase_pkg: shared simulation-side types for the CCI-P tracker and logger.
package ase_pkg;

    localparam int TRK_ERR_NUM = 6;

    // Lower code wins when several errors land in the same cycle.
    typedef enum logic [2:0] {
        ERR_DUP_TAG      = 3'd0,
        ERR_ORPHAN_RD    = 3'd1,
        ERR_BEAT_OVF     = 3'd2,
        ERR_WR_UNDERFLOW = 3'd3,
        ERR_ORPHAN_FENCE = 3'd4,
        ERR_TIMEOUT      = 3'd5
    } t_trk_err;

    typedef enum logic [1:0] {
        DRN_IDLE     = 2'd0,
        DRN_DRAINING = 2'd1,
        DRN_DONE     = 2'd2
    } t_trk_drain_state;

    // Lowest-numbered error present in the vector.
    function automatic t_trk_err trk_err_pick(input logic [TRK_ERR_NUM-1:0] v);
        t_trk_err code;
        code = ERR_DUP_TAG;
        for (int i = TRK_ERR_NUM - 1; i >= 0; i--) begin
            if (v[i]) code = t_trk_err'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/ccip_if_pkg.sv
// ccip_if_pkg: CCI-P header subset seen by the passive monitors on the rx/tx tap.
// Only the header fields and valid strobes the monitors decode are carried here.
package ccip_if_pkg;

    typedef logic [15:0] t_ccip_mdata;
    typedef logic [1:0]  t_ccip_clNum;
    typedef logic [41:0] t_ccip_clAddr;

    typedef enum logic [1:0] {
        eVC_VA  = 2'h0,
        eVC_VL0 = 2'h1,
        eVC_VH0 = 2'h2,
        eVC_VH1 = 2'h3
    } t_ccip_vc;

    // Encoding is lines-1, which the read tracker uses directly as beats_left.
    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef enum logic [3:0] {
        eRSP_WRLINE  = 4'h0,
        eRSP_WRFENCE = 4'h4,
        eRSP_INTR    = 4'h6
    } t_ccip_c1_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [5:0]   rsvd2;
        t_ccip_vc     vc_sel;
        logic         sop;
        logic         rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        t_ccip_clNum  cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic         format;
        logic         rsvd0;
        t_ccip_clNum  cl_num;
        t_ccip_c1_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
    } t_if_ccip_Tx;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

endpackage

// File: rtl/ccip_rd_tag_table.sv
// ccip_rd_tag_table: per-tag read state (busy, beats_left, original length).
// One retire port and one allocate port; a same-cycle retire of the final beat
// frees the entry so an allocate to the same tag succeeds.
module ccip_rd_tag_table #(
    parameter int TAG_BITS = 6
) (
    input  logic                clk,
    input  logic                SoftReset,
    input  logic [TAG_BITS-1:0] rsp_tag,
    input  logic                retire_en,
    output logic                rsp_busy,
    output logic [1:0]          rsp_len,
    input  logic [TAG_BITS-1:0] req_tag,
    input  logic [1:0]          req_len,
    input  logic                alloc_en,
    output logic                req_busy
);

    localparam int DEPTH = 1 << TAG_BITS;

    logic [DEPTH-1:0] busy;
    logic [1:0]       beats_left [DEPTH];
    logic [1:0]       len        [DEPTH];
    logic             rsp_last;

    assign rsp_busy = busy[rsp_tag];
    assign rsp_len  = len[rsp_tag];
    assign rsp_last = (beats_left[rsp_tag] == 2'd0);
    // Busy as seen by the request after this cycle's response has been applied.
    assign req_busy = busy[req_tag] && !(retire_en && rsp_last && (rsp_tag == req_tag));

    // Busy flags: retire first, allocate second so allocate wins on a shared tag.
    always_ff @(posedge clk) begin
        if (SoftReset) begin
            busy <= '0;
        end else begin
            if (retire_en && rsp_last) busy[rsp_tag] <= 1'b0;
            if (alloc_en)              busy[req_tag] <= 1'b1;
        end
    end

    // Beat bookkeeping; only meaningful while the matching busy bit is set.
    always_ff @(posedge clk) begin
        if (retire_en && !rsp_last) beats_left[rsp_tag] <= beats_left[rsp_tag] - 2'd1;
        if (alloc_en) begin
            beats_left[req_tag] <= req_len;
            len[req_tag]        <= req_len;
        end
    end

endmodule

// File: rtl/ccip_txn_tracker.sv
// ccip_txn_tracker: passive CCI-P scoreboard. Tracks in-flight reads per tag,
// outstanding write lines and fences, flags protocol errors as one-cycle events
// and raises finish_logger once a requested drain has quiesced.
module ccip_txn_tracker
    import ccip_if_pkg::*;
    import ase_pkg::*;
#(
    parameter int TAG_BITS       = 6,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   SoftReset,
    input  t_if_ccip_Rx            ccip_rx,
    input  t_if_ccip_Tx            ccip_tx,
    input  logic                   drain_req,
    output logic [CNT_W-1:0]       rd_outstanding,
    output logic [CNT_W-1:0]       wr_outstanding,
    output logic                   fence_pending,
    output logic                   err_valid,
    output t_trk_err               err_code,
    output logic [TRK_ERR_NUM-1:0] err_sticky,
    output logic [15:0]            err_tag,
    output logic                   finish_logger
);

    // Watchdog counts one past the limit and parks there, so the timeout fires once.
    localparam int              WD_W     = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    function automatic logic [CNT_W-1:0] cnt_sub_clamp(input logic [CNT_W-1:0] a,
                                                       input logic [2:0]       b);
        logic [CNT_W-1:0] bw;
        bw = CNT_W'(b);
        return (bw > a) ? '0 : (a - bw);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_add_sat(input logic [CNT_W-1:0] a,
                                                     input logic [2:0]       b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W + 1)'(b);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    logic [TAG_BITS-1:0]    req_tag, rsp_tag;
    logic [1:0]             req_len, rsp_len;
    logic [2:0]             req_lines, wr_retire;
    logic                   rd_req, rd_rsp, wr_req, wr_rsp, fence_req, fence_rsp;
    logic                   rsp_busy, req_busy, retire_en, alloc_en;
    logic                   quiet, wd_clear, timeout_hit;
    logic [TRK_ERR_NUM-1:0] err_vec;
    t_trk_err               err_pick;
    logic [15:0]            err_tag_sel;
    logic [WD_W-1:0]        wd_cnt_p1;
    t_trk_drain_state       state_p1;
    logic                   finish_sent_p1;

    assign req_tag   = ccip_tx.c0.hdr.mdata[TAG_BITS-1:0];
    assign rsp_tag   = ccip_rx.c0.hdr.mdata[TAG_BITS-1:0];
    assign req_len   = ccip_tx.c0.hdr.cl_len;
    assign req_lines = {1'b0, req_len} + 3'd1;
    assign wr_retire = ccip_rx.c1.hdr.format ? ({1'b0, ccip_rx.c1.hdr.cl_num} + 3'd1) : 3'd1;

    assign rd_req    = ccip_tx.c0.valid &&
                       ((ccip_tx.c0.hdr.req_type == eREQ_RDLINE_S) ||
                        (ccip_tx.c0.hdr.req_type == eREQ_RDLINE_I));
    assign rd_rsp    = ccip_rx.c0.rspValid && (ccip_rx.c0.hdr.resp_type == eRSP_RDLINE);
    assign wr_req    = ccip_tx.c1.valid &&
                       ((ccip_tx.c1.hdr.req_type == eREQ_WRLINE_I) ||
                        (ccip_tx.c1.hdr.req_type == eREQ_WRLINE_M) ||
                        (ccip_tx.c1.hdr.req_type == eREQ_WRPUSH_I));
    assign fence_req = ccip_tx.c1.valid && (ccip_tx.c1.hdr.req_type == eREQ_WRFENCE);
    assign wr_rsp    = ccip_rx.c1.rspValid && (ccip_rx.c1.hdr.resp_type == eRSP_WRLINE);
    assign fence_rsp = ccip_rx.c1.rspValid && (ccip_rx.c1.hdr.resp_type == eRSP_WRFENCE);

    ccip_rd_tag_table #(
        .TAG_BITS (TAG_BITS)
    ) u_tag_table (
        .clk       (clk),
        .SoftReset (SoftReset),
        .rsp_tag   (rsp_tag),
        .retire_en (retire_en),
        .rsp_busy  (rsp_busy),
        .rsp_len   (rsp_len),
        .req_tag   (req_tag),
        .req_len   (req_len),
        .alloc_en  (alloc_en),
        .req_busy  (req_busy)
    );

    // A beat beyond the original request length is reported, not retired.
    assign retire_en   = rd_rsp && rsp_busy && (ccip_rx.c0.hdr.cl_num <= rsp_len);
    assign alloc_en    = rd_req && !req_busy;

    assign quiet       = (rd_outstanding == '0) && (wr_outstanding == '0) && !fence_pending;
    assign wd_clear    = rd_rsp || wr_rsp || fence_rsp || quiet;
    assign timeout_hit = !wd_clear && (wd_cnt_p1 == WD_LIMIT);

    // Error detection for this cycle and selection of the reported code/tag.
    always_comb begin
        err_vec                   = '0;
        err_vec[ERR_DUP_TAG]      = rd_req && req_busy;
        err_vec[ERR_ORPHAN_RD]    = rd_rsp && !rsp_busy;
        err_vec[ERR_BEAT_OVF]     = rd_rsp && rsp_busy && (ccip_rx.c0.hdr.cl_num > rsp_len);
        err_vec[ERR_WR_UNDERFLOW] = wr_rsp && (CNT_W'(wr_retire) > wr_outstanding);
        err_vec[ERR_ORPHAN_FENCE] = fence_rsp && !fence_pending;
        err_vec[ERR_TIMEOUT]      = timeout_hit;
        err_pick                  = trk_err_pick(err_vec);
        err_tag_sel               = '0;
        case (err_pick)
            ERR_DUP_TAG:                        err_tag_sel = ccip_tx.c0.hdr.mdata;
            ERR_ORPHAN_RD, ERR_BEAT_OVF:        err_tag_sel = ccip_rx.c0.hdr.mdata;
            ERR_WR_UNDERFLOW, ERR_ORPHAN_FENCE: err_tag_sel = ccip_rx.c1.hdr.mdata;
            default:                            err_tag_sel = '0;
        endcase
    end

    // Outstanding counters and fence flag; responses retire before same-cycle requests add.
    always_ff @(posedge clk) begin
        if (SoftReset) begin
            rd_outstanding <= '0;
            wr_outstanding <= '0;
            fence_pending  <= 1'b0;
        end else begin
            rd_outstanding <= cnt_add_sat(cnt_sub_clamp(rd_outstanding, retire_en ? 3'd1 : 3'd0),
                                          alloc_en ? req_lines : 3'd0);
            wr_outstanding <= cnt_add_sat(cnt_sub_clamp(wr_outstanding, wr_rsp ? wr_retire : 3'd0),
                                          wr_req ? 3'd1 : 3'd0);
            if (fence_req)      fence_pending <= 1'b1;
            else if (fence_rsp) fence_pending <= 1'b0;
        end
    end

    // Response watchdog: cleared by any memory response or when nothing is in flight.
    always_ff @(posedge clk) begin
        if (SoftReset || wd_clear) wd_cnt_p1 <= '0;
        else if (wd_cnt_p1 <= WD_LIMIT) wd_cnt_p1 <= wd_cnt_p1 + 1'b1;
    end

    // Registered error event, sticky summary and offending tag.
    always_ff @(posedge clk) begin
        if (SoftReset) begin
            err_valid  <= 1'b0;
            err_code   <= ERR_DUP_TAG;
            err_sticky <= '0;
            err_tag    <= '0;
        end else begin
            err_valid  <= |err_vec;
            err_sticky <= err_sticky | err_vec;
            if (|err_vec) begin
                err_code <= err_pick;
                err_tag  <= err_tag_sel;
            end
        end
    end

    // Drain sequencer: wait for quiescence (or a timeout), then one finish pulse.
    always_ff @(posedge clk) begin
        if (SoftReset) begin
            state_p1       <= DRN_IDLE;
            finish_logger  <= 1'b0;
            finish_sent_p1 <= 1'b0;
        end else begin
            finish_logger <= 1'b0;
            case (state_p1)
                DRN_IDLE: begin
                    if (drain_req) state_p1 <= DRN_DRAINING;
                end
                DRN_DRAINING: begin
                    if (!drain_req)                 state_p1 <= DRN_IDLE;
                    else if (quiet || timeout_hit)  state_p1 <= DRN_DONE;
                end
                DRN_DONE: begin
                    finish_logger  <= !finish_sent_p1;
                    finish_sent_p1 <= 1'b1;
                end
                default: state_p1 <= DRN_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccip_txn_tracker.sv
// tb_ccip_txn_tracker: directed bench for the CCI-P transaction tracker.
module tb_ccip_txn_tracker;
    import ccip_if_pkg::*;
    import ase_pkg::*;

    localparam int TAG_BITS       = 6;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int CNT_W          = 16;

    logic                   clk = 1'b0;
    logic                   SoftReset;
    t_if_ccip_Rx            ccip_rx;
    t_if_ccip_Tx            ccip_tx;
    logic                   drain_req;
    logic [CNT_W-1:0]       rd_outstanding;
    logic [CNT_W-1:0]       wr_outstanding;
    logic                   fence_pending;
    logic                   err_valid;
    t_trk_err               err_code;
    logic [TRK_ERR_NUM-1:0] err_sticky;
    logic [15:0]            err_tag;
    logic                   finish_logger;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ccip_txn_tracker #(
        .TAG_BITS       (TAG_BITS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clk            (clk),
        .SoftReset      (SoftReset),
        .ccip_rx        (ccip_rx),
        .ccip_tx        (ccip_tx),
        .drain_req      (drain_req),
        .rd_outstanding (rd_outstanding),
        .wr_outstanding (wr_outstanding),
        .fence_pending  (fence_pending),
        .err_valid      (err_valid),
        .err_code       (err_code),
        .err_sticky     (err_sticky),
        .err_tag        (err_tag),
        .finish_logger  (finish_logger)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs set before the call are consumed, outputs sampled 1ns later.
    task automatic cycle();
        @(posedge clk);
        #1;
        ccip_tx.c0.valid    = 1'b0;
        ccip_tx.c1.valid    = 1'b0;
        ccip_rx.c0.rspValid = 1'b0;
        ccip_rx.c1.rspValid = 1'b0;
    endtask

    task automatic do_reset();
        drain_req = 1'b0;
        SoftReset = 1'b1;
        cycle();
        cycle();
        SoftReset = 1'b0;
    endtask

    task automatic set_rd_req(input logic [15:0] md, input t_ccip_clLen len);
        ccip_tx.c0.hdr          = '0;
        ccip_tx.c0.hdr.req_type = eREQ_RDLINE_S;
        ccip_tx.c0.hdr.cl_len   = len;
        ccip_tx.c0.hdr.mdata    = md;
        ccip_tx.c0.valid        = 1'b1;
    endtask

    task automatic set_rd_rsp(input logic [15:0] md, input logic [1:0] cl);
        ccip_rx.c0.hdr           = '0;
        ccip_rx.c0.hdr.resp_type = eRSP_RDLINE;
        ccip_rx.c0.hdr.cl_num    = cl;
        ccip_rx.c0.hdr.mdata     = md;
        ccip_rx.c0.rspValid      = 1'b1;
    endtask

    task automatic set_wr_req(input logic [15:0] md);
        ccip_tx.c1.hdr          = '0;
        ccip_tx.c1.hdr.req_type = eREQ_WRLINE_I;
        ccip_tx.c1.hdr.sop      = 1'b1;
        ccip_tx.c1.hdr.mdata    = md;
        ccip_tx.c1.valid        = 1'b1;
    endtask

    task automatic set_wr_rsp(input logic [15:0] md, input logic fmt, input logic [1:0] cl);
        ccip_rx.c1.hdr           = '0;
        ccip_rx.c1.hdr.resp_type = eRSP_WRLINE;
        ccip_rx.c1.hdr.format    = fmt;
        ccip_rx.c1.hdr.cl_num    = cl;
        ccip_rx.c1.hdr.mdata     = md;
        ccip_rx.c1.rspValid      = 1'b1;
    endtask

    task automatic set_fence_req();
        ccip_tx.c1.hdr          = '0;
        ccip_tx.c1.hdr.req_type = eREQ_WRFENCE;
        ccip_tx.c1.valid        = 1'b1;
    endtask

    task automatic set_fence_rsp(input logic [15:0] md);
        ccip_rx.c1.hdr           = '0;
        ccip_rx.c1.hdr.resp_type = eRSP_WRFENCE;
        ccip_rx.c1.hdr.mdata     = md;
        ccip_rx.c1.rspValid      = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL tb_time_limit observed=expired expected=finish");
        $fatal(1, "time limit");
    end

    initial begin
        ccip_rx   = '0;
        ccip_tx   = '0;
        drain_req = 1'b0;
        SoftReset = 1'b1;

        // Reset state
        do_reset();
        chk("rst_rd", rd_outstanding, 0);
        chk("rst_wr", wr_outstanding, 0);
        chk("rst_fence", fence_pending, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_sticky", err_sticky, 0);
        chk("rst_err_tag", err_tag, 0);
        chk("rst_finish", finish_logger, 0);

        // 4-line read, four beats back
        set_rd_req(16'h0005, eCL_LEN_4);
        cycle();
        chk("len4_rd_req", rd_outstanding, 4);
        for (int i = 0; i < 4; i++) begin
            set_rd_rsp(16'h0005, 2'(i));
            cycle();
            chk("len4_rd_beat", rd_outstanding, 32'(3 - i));
            chk("len4_no_err", err_valid, 0);
        end
        chk("len4_sticky", err_sticky, 0);

        // UMsg on c0 is ignored
        ccip_rx.c0.hdr           = '0;
        ccip_rx.c0.hdr.resp_type = eRSP_UMSG;
        ccip_rx.c0.rspValid      = 1'b1;
        cycle();
        chk("umsg_ignored", err_valid, 0);

        // Duplicate tag
        do_reset();
        set_rd_req(16'h0007, eCL_LEN_1);
        cycle();
        chk("dup_first_rd", rd_outstanding, 1);
        set_rd_req(16'h0007, eCL_LEN_1);
        cycle();
        chk("dup_valid", err_valid, 1);
        chk("dup_code", err_code, 0);
        chk("dup_tag", err_tag, 16'h0007);
        chk("dup_rd", rd_outstanding, 1);
        chk("dup_sticky", err_sticky, 6'b000001);
        cycle();
        chk("dup_one_cycle", err_valid, 0);

        // Orphan read response
        do_reset();
        set_rd_rsp(16'h0010, 2'd0);
        cycle();
        chk("orphan_valid", err_valid, 1);
        chk("orphan_code", err_code, 1);
        chk("orphan_tag", err_tag, 16'h0010);
        chk("orphan_sticky", err_sticky, 6'b000010);
        cycle();
        chk("orphan_one_cycle", err_valid, 0);
        chk("orphan_sticky_hold", err_sticky, 6'b000010);

        // Beat past the original length
        do_reset();
        set_rd_req(16'h0009, eCL_LEN_2);
        cycle();
        set_rd_rsp(16'h0009, 2'd2);
        cycle();
        chk("ovf_code", err_code, 2);
        chk("ovf_valid", err_valid, 1);
        chk("ovf_rd_unchanged", rd_outstanding, 2);
        set_rd_rsp(16'h0009, 2'd0);
        cycle();
        set_rd_rsp(16'h0009, 2'd1);
        cycle();
        chk("ovf_rd_drained", rd_outstanding, 0);

        // Write underflow from a packed response
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_wr_req(16'h0020);
            cycle();
            chk("wr_beat", wr_outstanding, 32'(i + 1));
        end
        set_wr_rsp(16'h0020, 1'b1, 2'd3);
        cycle();
        chk("wr_unf_valid", err_valid, 1);
        chk("wr_unf_code", err_code, 3);
        chk("wr_unf_tag", err_tag, 16'h0020);
        chk("wr_unf_clamp", wr_outstanding, 0);

        // Same-cycle write request and response, then packed retire
        do_reset();
        set_wr_req(16'h0001);
        cycle();
        set_wr_req(16'h0002);
        cycle();
        set_wr_req(16'h0003);
        set_wr_rsp(16'h0001, 1'b0, 2'd0);
        cycle();
        chk("wr_same_cycle", wr_outstanding, 2);
        set_wr_rsp(16'h0002, 1'b1, 2'd1);
        cycle();
        chk("wr_packed_retire", wr_outstanding, 0);
        chk("wr_packed_no_err", err_valid, 0);

        // Fence tracking and orphan fence
        do_reset();
        set_fence_rsp(16'h0044);
        cycle();
        chk("ofence_code", err_code, 4);
        chk("ofence_tag", err_tag, 16'h0044);
        set_fence_req();
        cycle();
        chk("fence_set", fence_pending, 1);
        set_fence_rsp(16'h0045);
        cycle();
        chk("fence_clr", fence_pending, 0);
        chk("fence_no_err", err_valid, 0);

        // Two errors in one cycle: lowest code reported, both sticky
        do_reset();
        set_rd_rsp(16'h0021, 2'd0);
        set_wr_rsp(16'h0033, 1'b0, 2'd0);
        cycle();
        chk("multi_code", err_code, 1);
        chk("multi_tag", err_tag, 16'h0021);
        chk("multi_sticky", err_sticky, 6'b001010);

        // Same-cycle final response and reallocation on tag 0x02, then SoftReset
        do_reset();
        set_rd_req(16'h0002, eCL_LEN_2);
        cycle();
        set_rd_rsp(16'h0002, 2'd0);
        cycle();
        chk("same_rd_mid", rd_outstanding, 1);
        set_rd_rsp(16'h0002, 2'd1);
        set_rd_req(16'h0002, eCL_LEN_4);
        cycle();
        chk("same_no_err", err_valid, 0);
        chk("same_rd", rd_outstanding, 4);
        set_rd_req(16'h0002, eCL_LEN_1);
        cycle();
        chk("same_rebusy_dup", err_valid, 1);
        chk("same_rebusy_code", err_code, 0);
        chk("same_rebusy_rd", rd_outstanding, 4);
        set_fence_req();
        cycle();
        SoftReset = 1'b1;
        cycle();
        chk("srst_rd", rd_outstanding, 0);
        chk("srst_fence", fence_pending, 0);
        chk("srst_sticky", err_sticky, 0);
        chk("srst_err_valid", err_valid, 0);
        chk("srst_err_tag", err_tag, 0);
        SoftReset = 1'b0;
        set_rd_rsp(16'h0002, 2'd2);
        cycle();
        chk("srst_orphan_code", err_code, 1);
        chk("srst_orphan_valid", err_valid, 1);

        // Timeout with drain requested
        do_reset();
        set_rd_req(16'h0011, eCL_LEN_1);
        cycle();
        drain_req = 1'b1;
        for (int i = 0; i < TIMEOUT_CYCLES; i++) cycle();
        chk("to_not_yet", err_valid, 0);
        cycle();
        chk("to_valid", err_valid, 1);
        chk("to_code", err_code, 5);
        chk("to_tag", err_tag, 0);
        chk("to_sticky", err_sticky, 6'b100000);
        chk("to_finish_early", finish_logger, 0);
        cycle();
        chk("to_finish", finish_logger, 1);
        chk("to_once", err_valid, 0);
        cycle();
        chk("to_finish_pulse", finish_logger, 0);
        cycle();
        chk("to_finish_stay", finish_logger, 0);

        // Drain withdrawn while busy, then a clean drain
        do_reset();
        set_rd_req(16'h0003, eCL_LEN_1);
        cycle();
        drain_req = 1'b1;
        cycle();
        cycle();
        drain_req = 1'b0;
        cycle();
        set_rd_rsp(16'h0003, 2'd0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("drain_withdrawn", finish_logger, 0);
        end
        drain_req = 1'b1;
        cycle();
        chk("drain_enter", finish_logger, 0);
        cycle();
        chk("drain_done", finish_logger, 0);
        cycle();
        chk("drain_finish", finish_logger, 1);
        cycle();
        chk("drain_finish_pulse", finish_logger, 0);
        drain_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ccip_txn_tracker.md
# ccip_txn_tracker

Passive CCI-P scoreboard on the same `ccip_rx`/`ccip_tx` tap as the transaction logger, one stage ahead of it. Tracks in-flight memory reads per mdata tag and outstanding write lines. Detects protocol errors (duplicate tag, orphan or over-length response, write underflow, response timeout) and emits one-cycle error events for the logger to print. Generates the logger's `finish_logger` strobe once a requested drain completes.

## Interface
- `TAG_BITS`, default 6: low mdata bits used as read tag; table depth is 2^TAG_BITS.
- `TIMEOUT_CYCLES`, default 4096: cycles without any memory response, while traffic is outstanding, before the timeout error fires.
- `CNT_W`, default 16: width of outstanding counters.
- `clk`, input, 1: single clock; all logic on posedge.
- `SoftReset`, input, 1: synchronous, active-high reset.
- `ccip_rx`, input, `t_if_ccip_Rx`: observed RX bus.
- `ccip_tx`, input, `t_if_ccip_Tx`: observed TX bus.
- `drain_req`, input, 1: level; request quiesce-then-finish.
- `rd_outstanding`, output, CNT_W: read lines in flight.
- `wr_outstanding`, output, CNT_W: write lines awaiting response.
- `fence_pending`, output, 1: WrFence issued, response not yet seen.
- `err_valid`, output, 1: one-cycle error event.
- `err_code`, output, 3: `t_trk_err` of the event.
- `err_sticky`, output, 6: one bit per error code, OR-accumulated.
- `err_tag`, output, 16: mdata of the offending transaction.
- `finish_logger`, output, 1: drives the logger's finish input.

## Operation
- Read table entry per tag: `busy` plus 2-bit `beats_left`.
- Read request: `c0.valid` with `eREQ_RDLINE_S` or `eREQ_RDLINE_I`.
  - Entry not busy: set busy; `beats_left` = lines−1 (eCL_LEN_1/2/4 gives 0/1/3); `rd_outstanding += lines`.
  - Entry busy: raise ERR_DUP_TAG; table and counter unchanged.
- Read response: `c0.rspValid` with `eRSP_RDLINE`.
  - Entry not busy: raise ERR_ORPHAN_RD.
  - Otherwise: `rd_outstanding -= 1`. If `beats_left` = 0, clear busy; else decrement `beats_left`.
  - Response with cl_num greater than the original request length: raise ERR_BEAT_OVF, no update.
- Write request: `c1.valid` with `eREQ_WRLINE_I`, `eREQ_WRLINE_M` or `eREQ_WRPUSH_I`, counted per valid beat: `wr_outstanding += 1`.
- Write response: `c1.rspValid` with `eRSP_WRLINE`.
  - Retires `format ? cl_num+1 : 1` lines.
  - Retiring more lines than outstanding: raise ERR_WR_UNDERFLOW, clamp `wr_outstanding` to 0.
- WrFence request sets `fence_pending`. WrFence response clears it. WrFence response while `fence_pending`=0 raises ERR_ORPHAN_FENCE.
- MMIO, UMsg and interrupt traffic is ignored.
- Watchdog counter:
  - Clears on any c0/c1 memory response, or whenever `rd_outstanding`, `wr_outstanding` and `fence_pending` are all zero.
  - Otherwise increments.
  - Reaching TIMEOUT_CYCLES raises ERR_TIMEOUT once, then the counter holds until cleared.
- Drain FSM, states IDLE → DRAINING → DONE:
  - IDLE → DRAINING on `drain_req`.
  - DRAINING → DONE when all counters are zero and `fence_pending`=0, or on ERR_TIMEOUT.
  - DONE pulses `finish_logger` for exactly one cycle, then stays in DONE until reset.
  - `drain_req` deassertion while DRAINING returns to IDLE.
- Multiple errors in one cycle: all set in `err_sticky`; `err_code`/`err_tag` report the lowest code.
  - Code order: DUP_TAG=0, ORPHAN_RD=1, BEAT_OVF=2, WR_UNDERFLOW=3, ORPHAN_FENCE=4, TIMEOUT=5.
  - For TIMEOUT, `err_tag` = 0.

## Timing
- All outputs are registered. Event at cycle N appears at cycle N+1.
- Reset values: all counters 0, table cleared, `fence_pending` 0, `err_*` 0, `finish_logger` 0, FSM IDLE.
- `SoftReset` mid-traffic discards all tracking state. Responses arriving after reset deassertion for pre-reset requests are reported as orphans; this is intended.
- Same-cycle request and response on the same tag: the response is applied first. If it retires the entry, the request allocates without ERR_DUP_TAG.
- Same-cycle read request and response change `rd_outstanding` by lines−1 net. Write paths behave the same way.
- Counters saturate at 2^CNT_W−1 and do not wrap.

## Structure
- Shared package `ase_pkg` gets `t_trk_err` enum and `TRK_ERR_NUM` = 6.
- Header typedefs come from `ccip_if_pkg`.
- Natural sub-module `ccip_rd_tag_table`: tag-indexed busy/beats_left storage with one allocate port and one retire port, same-cycle retire-before-allocate.

## Test plan
- eCL_LEN_4 read, mdata 0x05, then 4 RdLine responses cl_num 0–3 → `rd_outstanding` 4,3,2,1,0; no errors.
- Two reads mdata 0x07 back-to-back, no response → ERR_DUP_TAG, `err_tag`=0x0007, `rd_outstanding`=1.
- RdLine response mdata 0x10 with no request → `err_valid` one cycle, `err_code`=1, `err_sticky`[1]=1.
- 3 WrLine_I beats, then one packed response format=1 cl_num=3 → ERR_WR_UNDERFLOW, `wr_outstanding` ends at 0.
- TIMEOUT_CYCLES=16: single read, no response → ERR_TIMEOUT 17 cycles after the request. With `drain_req` high, `finish_logger` pulses once the cycle after.
- Same-cycle final response and new request on tag 0x02 → no error, entry re-busy, `rd_outstanding` correct. `SoftReset` mid-burst → all outputs 0 next cycle.
